// File: rtl/frame_trigger_scheduler.sv
// frame_trigger_scheduler
// Capture-side scheduler that decides when the frame buffer holds enough
// captured lines to start the read side. It issues a single starttrigger
// pulse per fill, and tracks lines and frames while running. It detects
// loss of input with a watchdog and restarts the schedule when the capture
// mode (line_doubler) changes.
module frame_trigger_scheduler #(
    parameter logic [11:0] FILL_LINES    = 12'd2,
    parameter logic [11:0] FILL_LINES_LD = 12'd4,
    parameter logic [11:0] LINES_MAX     = 12'd4095,
    parameter logic [20:0] TIMEOUT       = 21'd900900
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        line_doubler,
    input  logic        frame_start,
    input  logic        line_done,
    output logic        starttrigger,
    output logic        resync,
    output logic        signal_lost,
    output logic [2:0]  state,
    output logic [11:0] lines_written,
    output logic [7:0]  frame_count
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WAIT_FRAME = 3'd1,
        FILL       = 3'd2,
        RUN        = 3'd3,
        LOST       = 3'd4
    } state_t;

    state_t      state_q;
    state_t      state_nxt;
    logic        starttrigger_nxt;
    logic        resync_nxt;
    logic        signal_lost_nxt;
    logic [11:0] lines_written_nxt;
    logic [7:0]  frame_count_nxt;
    logic [20:0] watchdog;
    logic [20:0] watchdog_nxt;
    logic        line_doubler_q;

    logic        mode_change;
    logic [11:0] fill_threshold;
    logic [11:0] lines_inc;
    logic [20:0] watchdog_inc;
    logic        watchdog_expired;

    // The mode is compared against last cycle's sample; the threshold uses
    // the live value, which equals the sampled one whenever no change is seen.
    assign mode_change      = line_doubler ^ line_doubler_q;
    assign fill_threshold   = line_doubler ? FILL_LINES_LD : FILL_LINES;
    assign lines_inc        = lines_written + 12'd1;
    assign watchdog_inc     = watchdog + 21'd1;
    assign watchdog_expired = (watchdog_inc == TIMEOUT);

    assign state = state_q;

    // Next-state and next-output decode; enable and mode change dominate.
    always_comb begin
        state_nxt         = state_q;
        starttrigger_nxt  = 1'b0;
        resync_nxt        = 1'b0;
        signal_lost_nxt   = signal_lost;
        lines_written_nxt = lines_written;
        frame_count_nxt   = frame_count;
        watchdog_nxt      = watchdog;

        if (!enable) begin
            state_nxt         = IDLE;
            signal_lost_nxt   = 1'b0;
            lines_written_nxt = 12'd0;
            frame_count_nxt   = 8'd0;
            watchdog_nxt      = 21'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_nxt         = WAIT_FRAME;
                    signal_lost_nxt   = 1'b0;
                    lines_written_nxt = 12'd0;
                    frame_count_nxt   = 8'd0;
                    watchdog_nxt      = 21'd0;
                end

                WAIT_FRAME, FILL, RUN, LOST: begin
                    if (mode_change) begin
                        // Stored lines were captured in the old mode; start over.
                        state_nxt         = WAIT_FRAME;
                        resync_nxt        = 1'b1;
                        signal_lost_nxt   = 1'b0;
                        lines_written_nxt = 12'd0;
                        frame_count_nxt   = 8'd0;
                        watchdog_nxt      = 21'd0;
                    end else begin
                        case (state_q)
                            WAIT_FRAME: begin
                                // Lines from a partial frame are not counted.
                                if (frame_start) begin
                                    state_nxt         = FILL;
                                    lines_written_nxt = 12'd0;
                                    watchdog_nxt      = 21'd0;
                                end
                            end

                            FILL: begin
                                if (frame_start) begin
                                    // A new frame restarts the fill; any
                                    // simultaneous line_done is dropped.
                                    lines_written_nxt = 12'd0;
                                    watchdog_nxt      = 21'd0;
                                end else if (watchdog_expired) begin
                                    state_nxt         = LOST;
                                    signal_lost_nxt   = 1'b1;
                                    lines_written_nxt = 12'd0;
                                    watchdog_nxt      = 21'd0;
                                end else begin
                                    watchdog_nxt = watchdog_inc;
                                    if (line_done) begin
                                        lines_written_nxt = lines_inc;
                                        if (lines_inc == fill_threshold) begin
                                            state_nxt        = RUN;
                                            starttrigger_nxt = 1'b1;
                                            frame_count_nxt  = 8'd0;
                                        end
                                    end
                                end
                            end

                            RUN: begin
                                if (frame_start) begin
                                    lines_written_nxt = 12'd0;
                                    frame_count_nxt   = frame_count + 8'd1;
                                    watchdog_nxt      = 21'd0;
                                end else if (watchdog_expired) begin
                                    state_nxt         = LOST;
                                    signal_lost_nxt   = 1'b1;
                                    lines_written_nxt = 12'd0;
                                    watchdog_nxt      = 21'd0;
                                end else begin
                                    watchdog_nxt = watchdog_inc;
                                    if (line_done && (lines_written != LINES_MAX)) begin
                                        lines_written_nxt = lines_inc;
                                    end
                                end
                            end

                            LOST: begin
                                // Input came back: refill from scratch.
                                watchdog_nxt = 21'd0;
                                if (frame_start) begin
                                    state_nxt         = FILL;
                                    signal_lost_nxt   = 1'b0;
                                    frame_count_nxt   = 8'd0;
                                    lines_written_nxt = 12'd0;
                                    resync_nxt        = 1'b1;
                                end
                            end

                            default: begin
                                state_nxt = IDLE;
                            end
                        endcase
                    end
                end

                default: begin
                    // Unused encodings recover through IDLE.
                    state_nxt         = IDLE;
                    signal_lost_nxt   = 1'b0;
                    lines_written_nxt = 12'd0;
                    frame_count_nxt   = 8'd0;
                    watchdog_nxt      = 21'd0;
                end
            endcase
        end
    end

    // State and output registers; resync is masked so it can never stretch.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            starttrigger   <= 1'b0;
            resync         <= 1'b0;
            signal_lost    <= 1'b0;
            lines_written  <= 12'd0;
            frame_count    <= 8'd0;
            watchdog       <= 21'd0;
            line_doubler_q <= 1'b0;
        end else begin
            state_q        <= state_nxt;
            starttrigger   <= starttrigger_nxt & ~starttrigger;
            resync         <= resync_nxt & ~resync;
            signal_lost    <= signal_lost_nxt;
            lines_written  <= lines_written_nxt;
            frame_count    <= frame_count_nxt;
            watchdog       <= watchdog_nxt;
            line_doubler_q <= line_doubler;
        end
    end

endmodule
